// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LU_STALL = 2'd1,
      MC_BUSY  = 2'd2
   } hz_state_e;

   localparam int REG_X0         = 0;
   localparam int DEF_LOAD_STALL = 1;
   localparam int DEF_MC_LATENCY = 4;

endpackage

// File: rtl/hazard_lu_cmp.sv
// Combinational load-use comparator: flags an ID source read of a pending load destination.
module hazard_lu_cmp
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              mem_read,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              rs1_used,
   input  logic              rs2_used,
   output logic              hit
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign hit = mem_read && (rd != REG_AW'(REG_X0)) &&
                ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: multi-cycle load-use stall, EX hold for multi-cycle ops, taken-branch flush.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int LOAD_STALL = DEF_LOAD_STALL,
   parameter int MC_LATENCY = DEF_MC_LATENCY,
   parameter int CNT_W      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_ex_mem_read,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic [REG_AW-1:0] if_id_rs1,
   input  logic [REG_AW-1:0] if_id_rs2,
   input  logic              if_id_rs1_used,
   input  logic              if_id_rs2_used,
   input  logic              id_ex_mc_op,
   input  logic              ex_branch_taken,
   output logic              stall,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              id_ex_write_en,
   output logic              id_ex_bubble,
   output logic              ex_mem_bubble,
   output logic              flush_if_id,
   output logic              mc_done
);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lu_hit;

   hazard_lu_cmp #(.REG_AW(REG_AW)) u_lu_cmp (
      .mem_read (id_ex_mem_read),
      .rd       (id_ex_rd),
      .rs1      (if_id_rs1),
      .rs2      (if_id_rs2),
      .rs1_used (if_id_rs1_used),
      .rs2_used (if_id_rs2_used),
      .hit      (lu_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stall          = 1'b0;
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      id_ex_write_en = 1'b1;
      id_ex_bubble   = 1'b0;
      ex_mem_bubble  = 1'b0;
      flush_if_id    = 1'b0;
      mc_done        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ex_branch_taken) begin
               flush_if_id  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (id_ex_mc_op) begin
               stall          = 1'b1;
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_write_en = 1'b0;
               ex_mem_bubble  = 1'b1;
               cnt_d          = CNT_W'(MC_LATENCY - 2);
               state_d        = MC_BUSY;
            end else if (lu_hit) begin
               stall          = 1'b1;
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_bubble   = 1'b1;
               if (LOAD_STALL > 1) begin
                  cnt_d   = CNT_W'(LOAD_STALL - 2);
                  state_d = LU_STALL;
               end
            end
         end
         // EX still holds the mc op, so branch and load-use inputs are not meaningful here.
         MC_BUSY: begin
            if (cnt_q != '0) begin
               stall          = 1'b1;
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_write_en = 1'b0;
               ex_mem_bubble  = 1'b1;
               cnt_d          = cnt_q - CNT_W'(1);
            end else begin
               mc_done = 1'b1;
               state_d = IDLE;
            end
         end
         LU_STALL: begin
            if (ex_branch_taken) begin
               flush_if_id  = 1'b1;
               id_ex_bubble = 1'b1;
               state_d      = IDLE;
            end else begin
               stall          = 1'b1;
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_bubble   = 1'b1;
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are combinational, so reset must mask whatever the inputs are doing.
      if (!rst_n) begin
         stall          = 1'b0;
         pc_write_en    = 1'b1;
         if_id_write_en = 1'b1;
         id_ex_write_en = 1'b1;
         id_ex_bubble   = 1'b0;
         ex_mem_bubble  = 1'b0;
         flush_if_id    = 1'b0;
         mc_done        = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (rst_n) assert (!(id_ex_mc_op && id_ex_mem_read));
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: three hazard controllers with different stall/latency settings share one stimulus.
module tb_hazard_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_read;
   logic [4:0] rd, rs1, rs2;
   logic       rs1_used, rs2_used, mc_op, br;

   // Packed view: {stall, pc_we, if_id_we, id_ex_we, id_ex_bub, ex_mem_bub, flush, mc_done}
   logic [7:0] oa, ob, oc;

   localparam logic [7:0] DEF  = 8'b0111_0000;
   localparam logic [7:0] STL  = 8'b1001_1000;
   localparam logic [7:0] HLD  = 8'b1000_0100;
   localparam logic [7:0] BR   = 8'b0111_1010;
   localparam logic [7:0] DONE = 8'b0111_0001;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(1), .MC_LATENCY(4), .CNT_W(3)) u_a (
      .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
      .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
      .id_ex_mc_op(mc_op), .ex_branch_taken(br),
      .stall(oa[7]), .pc_write_en(oa[6]), .if_id_write_en(oa[5]), .id_ex_write_en(oa[4]),
      .id_ex_bubble(oa[3]), .ex_mem_bubble(oa[2]), .flush_if_id(oa[1]), .mc_done(oa[0])
   );

   hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(3), .MC_LATENCY(4), .CNT_W(3)) u_b (
      .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
      .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
      .id_ex_mc_op(mc_op), .ex_branch_taken(br),
      .stall(ob[7]), .pc_write_en(ob[6]), .if_id_write_en(ob[5]), .id_ex_write_en(ob[4]),
      .id_ex_bubble(ob[3]), .ex_mem_bubble(ob[2]), .flush_if_id(ob[1]), .mc_done(ob[0])
   );

   hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(7), .MC_LATENCY(2), .CNT_W(3)) u_c (
      .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
      .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
      .id_ex_mc_op(mc_op), .ex_branch_taken(br),
      .stall(oc[7]), .pc_write_en(oc[6]), .if_id_write_en(oc[5]), .id_ex_write_en(oc[4]),
      .id_ex_bubble(oc[3]), .ex_mem_bubble(oc[2]), .flush_if_id(oc[1]), .mc_done(oc[0])
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic clr();
      mem_read = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      rs1_used = 1'b0; rs2_used = 1'b0; mc_op = 1'b0; br = 1'b0;
   endtask

   task automatic lu_inputs();
      mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      rst_n = 1'b0;
      lu_inputs();
      #1;
      chk("reset_a", oa, DEF);
      chk("reset_b", ob, DEF);
      chk("reset_c", oc, DEF);
      tick();
      clr();
      rst_n = 1'b1;
      tick();

      // Load-use: load leaves EX after the first cycle, stall count depends on LOAD_STALL.
      lu_inputs();
      #1;
      chk("lu_c1_a", oa, STL);
      chk("lu_c1_b", ob, STL);
      chk("lu_c1_c", oc, STL);
      tick();
      clr();
      for (int i = 2; i <= 8; i++) begin
         #1;
         chk($sformatf("lu_c%0d_a", i), oa, DEF);
         chk($sformatf("lu_c%0d_b", i), ob, (i <= 3) ? STL : DEF);
         chk($sformatf("lu_c%0d_c", i), oc, (i <= 7) ? STL : DEF);
         tick();
      end

      // Combinational qualification checks within one idle cycle.
      mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
      #1;
      chk("x0_nohaz", ob, DEF);
      rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; rs2_used = 1'b0;
      #1;
      chk("rs2_unused", ob, DEF);
      rs2_used = 1'b1;
      #1;
      chk("rs2_used", ob, STL);
      mem_read = 1'b0;
      #1;
      chk("no_load", ob, DEF);
      clr();
      tick();

      // Branch beats lu_hit in IDLE.
      lu_inputs();
      br = 1'b1;
      #1;
      chk("br_idle_a", oa, BR);
      chk("br_idle_b", ob, BR);
      tick();
      clr();
      #1;
      chk("br_after_a", oa, DEF);
      chk("br_after_b", ob, DEF);
      tick();

      // Branch during LU_STALL aborts the stall.
      lu_inputs();
      tick();
      clr();
      br = 1'b1;
      #1;
      chk("br_lus_b", ob, BR);
      chk("br_lus_c", oc, BR);
      tick();
      clr();
      #1;
      chk("br_lus_after_b", ob, DEF);
      chk("br_lus_after_c", oc, DEF);
      tick();

      // Multi-cycle ops back to back; branch in cycle 2 is ignored by MC_BUSY.
      for (int i = 1; i <= 8; i++) begin
         mc_op = 1'b1;
         br = (i == 2);
         #1;
         chk($sformatf("mc_c%0d_a", i), oa, (i % 4 == 0) ? DONE : HLD);
         chk($sformatf("mc_c%0d_c", i), oc, (i % 2 == 0) ? DONE : HLD);
         tick();
      end
      clr();
      #1;
      chk("mc_end_a", oa, DEF);
      chk("mc_end_c", oc, DEF);
      tick();

      // Asynchronous reset in the second MC_BUSY cycle.
      mc_op = 1'b1;
      #1;
      chk("mcr_c1_a", oa, HLD);
      tick();
      #1;
      chk("mcr_c2_a", oa, HLD);
      chk("mcr_c2_c", oc, DONE);
      rst_n = 1'b0;
      #1;
      chk("mcr_async_a", oa, DEF);
      chk("mcr_async_c", oc, DEF);
      tick();
      clr();
      #1;
      rst_n = 1'b1;
      #1;
      chk("mcr_rel_a", oa, DEF);
      tick();
      chk("mcr_post_a", oa, DEF);
      chk("mcr_post_b", ob, DEF);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage RISC-V core. It generalises single-cycle load-use detection in three ways: a configurable multi-cycle load-use stall length, rs-used qualification with x0 exclusion, and EX-stage hold for multi-cycle ops such as mul/div. It also drives the flush controls for a taken branch resolved in EX. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM register enables, bubbles and flushes.

Parameters:
REG_AW, 5, register address width
LOAD_STALL, 1, bubble cycles inserted per load-use hazard (1..7)
MC_LATENCY, 4, cycles a multi-cycle op occupies EX (2..8)
CNT_W, 3, stall counter width; must hold max(LOAD_STALL-1, MC_LATENCY-2)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REG_AW  destination of instruction in EX
if_id_rs1  in  REG_AW  rs1 of instruction in ID
if_id_rs2  in  REG_AW  rs2 of instruction in ID
if_id_rs1_used  in  1  ID instruction reads rs1
if_id_rs2_used  in  1  ID instruction reads rs2
id_ex_mc_op  in  1  instruction in EX is multi-cycle
ex_branch_taken  in  1  taken branch/jump resolved in EX
stall  out  1  front-end stall (load-use or mc hold)
pc_write_en  out  1  PC update enable
if_id_write_en  out  1  IF/ID register enable
id_ex_write_en  out  1  ID/EX register enable
id_ex_bubble  out  1  load NOP into ID/EX
ex_mem_bubble  out  1  load NOP into EX/MEM
flush_if_id  out  1  squash IF/ID
mc_done  out  1  one-cycle pulse: mc op leaves EX this cycle

Behaviour:
- State: IDLE, LU_STALL, MC_BUSY; counter cnt[CNT_W].
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0. Outputs are forced to: stall=0, pc_write_en=1, if_id_write_en=1, id_ex_write_en=1, id_ex_bubble=0, ex_mem_bubble=0, flush_if_id=0, mc_done=0.
- Outputs are combinational from state and inputs.
- Defaults: all enables=1, all bubbles, flushes and stall=0.
- lu_hit = id_ex_mem_read & (id_ex_rd!=0) & ((rs1_used & rd==rs1) | (rs2_used & rd==rs2)).
- "Stall action" means: stall=1, pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
- "Hold action" means: stall=1, pc_write_en=0, if_id_write_en=0, id_ex_write_en=0, ex_mem_bubble=1.
- Priority within IDLE: ex_branch_taken > id_ex_mc_op > lu_hit.
- IDLE transitions:
  - ex_branch_taken: flush_if_id=1, id_ex_bubble=1, PC writes; stay IDLE.
  - id_ex_mc_op: hold action; cnt<=MC_LATENCY-2; go MC_BUSY.
  - lu_hit: stall action. If LOAD_STALL>1: cnt<=LOAD_STALL-2, go LU_STALL; otherwise stay IDLE.
- MC_BUSY:
  - cnt!=0: hold action, cnt--.
  - cnt==0: no hold; mc_done=1; go IDLE.
  - Net effect: the mc op occupies EX exactly MC_LATENCY cycles with MC_LATENCY-1 hold cycles.
  - Inputs lu_hit and ex_branch_taken are ignored here, because EX holds the mc op.
- LU_STALL:
  - Stall action every cycle (the load has left EX, so lu_hit is not re-evaluated).
  - cnt==0: go IDLE after this cycle; otherwise cnt--.
  - Total bubbles = LOAD_STALL.
- ex_branch_taken in LU_STALL (defensive): flush outputs as in IDLE, stall deasserted, go IDLE.
- Back-to-back mc ops: the second enters EX the cycle after mc_done and restarts from IDLE; there is no dead cycle.
- x0 is never a hazard source. A match on an unused rs field is not a hazard.
- rst_n asserted mid-stall or mid-hold: abort immediately to the reset values. No pulse is replayed.
- Simulation assertion: id_ex_mc_op & id_ex_mem_read must never be high together.

Decomposition:
- Shared package hazard_pkg holds: state enum {IDLE, LU_STALL, MC_BUSY}, REG_X0 constant, and default LOAD_STALL/MC_LATENCY constants.
- One sub-module, hazard_lu_cmp: the combinational lu_hit comparator, reused by the forwarding checks.
- FSM and counter stay in the top module.

Test Plan:
- LOAD_STALL=1; load rd=5 in EX, ID rs1=5 used → stall=1 for 1 cycle, id_ex_bubble=1, pc_write_en=0; next cycle all defaults.
- LOAD_STALL=3; same stimulus → stall=1 for exactly 3 consecutive cycles, then released; id_ex_rd=0 or rs2=5 with rs2_used=0 → no stall.
- MC_LATENCY=4; id_ex_mc_op held until mc_done → hold asserted 3 cycles, mc_done pulses in cycle 4, ex_mem_bubble=1 during the 3 holds; back-to-back mc ops → 3 holds, mc_done, 3 holds, mc_done.
- ex_branch_taken with lu_hit-looking inputs in IDLE → flush_if_id=1, id_ex_bubble=1, pc_write_en=1, stall=0.
- rst_n pulled low in the 2nd MC_BUSY cycle → outputs take reset values asynchronously (within the same cycle); after release, state IDLE and no mc_done.
- MC_LATENCY=2 and LOAD_STALL=7 corner cases → hold exactly 1 cycle; stall exactly 7 cycles with cnt reaching 0 without wrap.
